// File: rtl/mult_control.sv
// Sequencing FSM for the shift-and-add multiplier: drives Load/Ad/Sh into the
// accumulator from St and the fed-back multiplier LSB, with a Done/St handshake.
module mult_control #(
   parameter int N  = 4,
   parameter int CW = 3
) (
   input  logic Clk,
   input  logic Rst,
   input  logic St,
   input  logic M,
   output logic Load,
   output logic Ad,
   output logic Sh,
   output logic Done,
   output logic Busy
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      TEST,
      ADD,
      SHIFT,
      DONE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;

   // Outputs are registered alongside the state: each branch loads the
   // output pattern belonging to the state being entered.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         Load    <= 1'b0;
         Ad      <= 1'b0;
         Sh      <= 1'b0;
         Done    <= 1'b0;
         Busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (St) begin
                  r_state <= LOAD;
                  Load    <= 1'b1;
                  Busy    <= 1'b1;
               end
            end
            LOAD: begin
               r_state <= TEST;
               r_cnt   <= '0;
               Load    <= 1'b0;
            end
            TEST: begin
               if (M) begin
                  r_state <= ADD;
                  Ad      <= 1'b1;
               end else begin
                  r_state <= SHIFT;
                  Sh      <= 1'b1;
               end
            end
            ADD: begin
               r_state <= SHIFT;
               Ad      <= 1'b0;
               Sh      <= 1'b1;
            end
            SHIFT: begin
               Sh    <= 1'b0;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(N - 1)) begin
                  r_state <= DONE;
                  Done    <= 1'b1;
                  Busy    <= 1'b0;
               end else begin
                  r_state <= TEST;
               end
            end
            DONE: begin
               if (!St) begin
                  r_state <= IDLE;
                  Done    <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               Load    <= 1'b0;
               Ad      <= 1'b0;
               Sh      <= 1'b0;
               Done    <= 1'b0;
               Busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: the controller drives a behavioural 9-bit accumulator
// and each run is compared with product/popcount arithmetic.
module tb_mult_control;
   localparam int N  = 4;
   localparam int CW = 3;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       St  = 1'b0;
   logic       M;
   logic       Load, Ad, Sh, Done, Busy;
   logic [8:0] r_acc = '0;
   logic [3:0] r_mpl = '0;
   logic [3:0] r_mcd = '0;
   int         n_vec = 0;
   int         n_err = 0;

   mult_control #(.N(N), .CW(CW)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .St  (St),
      .M   (M),
      .Load(Load),
      .Ad  (Ad),
      .Sh  (Sh),
      .Done(Done),
      .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   // Accumulator: {carry, high nibble, multiplier nibble}
   assign M = r_acc[0];
   always @(posedge Clk) begin
      if (Load)    r_acc <= {5'b0, r_mpl};
      else if (Ad) r_acc[8:4] <= {1'b0, r_acc[7:4]} + {1'b0, r_mcd};
      else if (Sh) r_acc <= r_acc >> 1;
   end

   // mode: 0 = one-cycle St pulse, 1 = St held high, 2 = St toggled every cycle
   task automatic run_mult(input logic [3:0] mpl, input logic [3:0] mcd, input int mode, input string tag);
      int pop      = $countones(mpl);
      int exp_done = 2 + 2 * N + pop;
      int exp_busy = 1 + 2 * N + pop;
      logic [8:0] exp_acc = 9'(int'(mpl) * int'(mcd));
      int busy_n = 0, ad_n = 0, sh_n = 0, ld_n = 0, ld_first = -1;
      int ovl = 0, adsh = 0, done_cyc = -1;
      logic prev_ad = 1'b0;
      r_mpl = mpl;
      r_mcd = mcd;
      @(negedge Clk);
      St = 1'b1;
      @(posedge Clk);
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         @(negedge Clk);
         if (mode == 0) St = 1'b0;
         else if (mode == 2) St = ~St;
         if (Load && ld_first < 0) ld_first = c;
         ld_n   += int'(Load);
         ad_n   += int'(Ad);
         sh_n   += int'(Sh);
         busy_n += int'(Busy);
         if (int'(Load) + int'(Ad) + int'(Sh) > 1) ovl++;
         if (prev_ad && !Sh) adsh++;
         prev_ad = Ad;
         if (Done) done_cyc = c;
      end
      if (mode != 1) St = 1'b0;
      n_vec++; if (done_cyc !== exp_done) begin n_err++; $display("FAIL %s done_cycle got %0d want %0d", tag, done_cyc, exp_done); end
      n_vec++; if (ld_first !== 1) begin n_err++; $display("FAIL %s load_cycle got %0d want 1", tag, ld_first); end
      n_vec++; if (ld_n !== 1) begin n_err++; $display("FAIL %s load_count got %0d want 1", tag, ld_n); end
      n_vec++; if (ad_n !== pop) begin n_err++; $display("FAIL %s ad_count got %0d want %0d", tag, ad_n, pop); end
      n_vec++; if (sh_n !== N) begin n_err++; $display("FAIL %s sh_count got %0d want %0d", tag, sh_n, N); end
      n_vec++; if (busy_n !== exp_busy) begin n_err++; $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_n, exp_busy); end
      n_vec++; if (ovl !== 0) begin n_err++; $display("FAIL %s strobe_overlap got %0d want 0", tag, ovl); end
      n_vec++; if (adsh !== 0) begin n_err++; $display("FAIL %s ad_then_sh got %0d want 0", tag, adsh); end
      n_vec++; if (r_acc !== exp_acc) begin n_err++; $display("FAIL %s product got %0d want %0d", tag, r_acc, exp_acc); end
      if (mode == 1) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            n_vec++; if ({Done, Load, Busy} !== 3'b100) begin n_err++; $display("FAIL %s done_hold got %b want 100", tag, {Done, Load, Busy}); end
         end
         St = 1'b0;
      end
      @(negedge Clk);
      n_vec++; if ({Done, Busy, Load} !== 3'b000) begin n_err++; $display("FAIL %s done_release got %b want 000", tag, {Done, Busy, Load}); end
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      St  = 1'b0;
      @(negedge Clk);
      n_vec++; if ({Load, Ad, Sh, Done, Busy} !== 5'b0) begin n_err++; $display("FAIL reset_outputs got %b want 00000", {Load, Ad, Sh, Done, Busy}); end
      Rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         n_vec++; if ({Load, Ad, Sh, Done, Busy} !== 5'b0) begin n_err++; $display("FAIL idle_outputs got %b want 00000", {Load, Ad, Sh, Done, Busy}); end
      end
   endtask

   task automatic test_zero_mult();
      run_mult(4'd0, 4'd11, 0, "zero_mult");
   endtask

   task automatic test_mult_13();
      run_mult(4'd13, 4'd11, 0, "mult_13x11");
   endtask

   task automatic test_held_start();
      run_mult(4'd15, 4'd15, 1, "held_15x15");
   endtask

   task automatic test_reset_midop();
      int ad_n = 0;
      logic hit = 1'b0;
      r_mpl = 4'd13;
      r_mcd = 4'd11;
      @(negedge Clk);
      St = 1'b1;
      @(posedge Clk);
      for (int c = 1; c <= 20 && !hit; c++) begin
         @(negedge Clk);
         St = 1'b0;
         ad_n += int'(Ad);
         if (ad_n == 2) begin
            #2 Rst = 1'b1;
            #1;
            hit = 1'b1;
            n_vec++; if ({Load, Ad, Sh, Done, Busy} !== 5'b0) begin n_err++; $display("FAIL midop_reset got %b want 00000", {Load, Ad, Sh, Done, Busy}); end
         end
      end
      n_vec++; if (!hit) begin n_err++; $display("FAIL midop_second_ad got none want one"); end
      @(negedge Clk);
      Rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         n_vec++; if ({Done, Busy} !== 2'b00) begin n_err++; $display("FAIL midop_quiet got %b want 00", {Done, Busy}); end
      end
      run_mult(4'd13, 4'd11, 0, "midop_restart");
   endtask

   task automatic test_start_during_busy();
      run_mult(4'd7, 4'd15, 2, "toggle_7x15");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         run_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_zero_mult();
      test_mult_13();
      test_held_start();
      test_reset_midop();
      test_start_during_busy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
